// File: rtl/vga_frame_ctrl.sv
// rtl/vga_frame_ctrl.sv - VGA timing generator with per-frame register shadow fetch
module vga_frame_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit SYNC_POL = 1'b0,
    parameter int NREGS    = 16,
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int CW       = 4,
    parameter int PW       = 10,
    parameter int MEM_LAT  = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic [AW-1:0]   MemAddrOut,
    output logic            MemRdEn,
    input  logic [DW-1:0]   MemDataIN,
    input  logic            FreezeIn,
    input  logic            PixelIn,
    input  logic [3*CW-1:0] FgColor,
    input  logic [3*CW-1:0] BgColor,
    input  logic [AW-1:0]   ShadowSel,
    output logic [DW-1:0]   ShadowData,
    output logic            HSync,
    output logic            VSync,
    output logic [CW-1:0]   R,
    output logic [CW-1:0]   G,
    output logic [CW-1:0]   B,
    output logic [PW-1:0]   PosX,
    output logic [PW-1:0]   PosY,
    output logic            VideoOn,
    output logic            FetchDone,
    output logic            ShadowValid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int TW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DLW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [PW-1:0] H_LAST   = PW'(H_TOTAL - 1);
    localparam logic [PW-1:0] V_LAST   = PW'(V_TOTAL - 1);
    localparam logic [PW-1:0] H_VIS    = PW'(H_ACTIVE);
    localparam logic [PW-1:0] V_VIS    = PW'(V_ACTIVE);
    localparam logic [PW-1:0] HS_START = PW'(H_ACTIVE + H_FP);
    localparam logic [PW-1:0] HS_END   = PW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [PW-1:0] VS_START = PW'(V_ACTIVE + V_FP);
    localparam logic [PW-1:0] VS_END   = PW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [PW-1:0]   next_x;
    logic [PW-1:0]   next_y;
    logic            next_video;
    logic            fetch_start;
    logic [3*CW-1:0] pix_color;
    state_t          state;
    logic [DLW-1:0]  drain_cnt;
    logic [MEM_LAT-1:0] pipe_vld;
    logic [AW-1:0]   pipe_addr [MEM_LAT];
    logic [DW-1:0]   shadow [NREGS];

    assign tick = (tick_cnt == TW'(CLK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Position the counters will hold after this edge; all video outputs are
    // registered from it so they line up with PosX/PosY.
    always_comb begin
        next_x = PosX;
        next_y = PosY;
        if (tick) begin
            if (PosX == H_LAST) begin
                next_x = '0;
                next_y = (PosY == V_LAST) ? '0 : PosY + 1'b1;
            end else begin
                next_x = PosX + 1'b1;
            end
        end
    end

    assign next_video  = (next_x < H_VIS) && (next_y < V_VIS);
    assign pix_color   = PixelIn ? FgColor : BgColor;
    assign fetch_start = tick && (next_x == '0) && (next_y == V_VIS);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PosX    <= '0;
            PosY    <= '0;
            HSync   <= ~SYNC_POL;
            VSync   <= ~SYNC_POL;
            VideoOn <= 1'b0;
            {R, G, B} <= '0;
        end else if (tick) begin
            PosX    <= next_x;
            PosY    <= next_y;
            HSync   <= (next_x >= HS_START && next_x < HS_END) ? SYNC_POL : ~SYNC_POL;
            VSync   <= (next_y >= VS_START && next_y < VS_END) ? SYNC_POL : ~SYNC_POL;
            VideoOn <= next_video;
            {R, G, B} <= next_video ? pix_color : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            MemRdEn     <= 1'b0;
            MemAddrOut  <= '0;
            FetchDone   <= 1'b0;
            ShadowValid <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            FetchDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start && !FreezeIn) begin
                        state      <= ISSUE;
                        MemRdEn    <= 1'b1;
                        MemAddrOut <= '0;
                    end
                end
                ISSUE: begin
                    if (MemAddrOut == AW'(NREGS - 1)) begin
                        state     <= DRAIN;
                        MemRdEn   <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        MemAddrOut <= MemAddrOut + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DLW'(MEM_LAT - 1)) begin
                        state       <= IDLE;
                        FetchDone   <= 1'b1;
                        ShadowValid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address/valid delay line matching the memory latency; clearing the
    // valids on reset is what drops in-flight read data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= MemRdEn;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        pipe_addr[0] <= MemAddrOut;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && pipe_vld[MEM_LAT-1]) begin
            shadow[pipe_addr[MEM_LAT-1]] <= MemDataIN;
        end
    end

    assign ShadowData = shadow[ShadowSel];

endmodule
